fixed3_mad_scheduler: RTL and testbench
=======================================

# fixed3_mad_scheduler

Round-robin scheduler that shares one pipelined Fixed3 multiply-add unit (ov = c + a·b per dimension) among NUM_REQ requesters in the shading/intersection datapath. It accepts one operation per cycle through per-requester valid/ready handshakes and drives the shared unit's operands. A tag pipeline matched to the unit's latency routes each result back to its originating requester as a one-hot result strobe.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- MAD_LATENCY, default 1: cycles from operands presented on mad_* to result valid on mad_ov, 1..8.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, per requester.
- req_ready  out  NUM_REQ  grant; handshake completes on req_valid[i] & req_ready[i].
- req_c  in  Fixed3 [NUM_REQ]  addend.
- req_a  in  Fixed [NUM_REQ]  scalar multiplier.
- req_b  in  Fixed3 [NUM_REQ]  vector multiplicand.
- hold  in  1  block new grants; in-flight ops still retire.
- flush  in  1  discard all in-flight ops.
- mad_c  out  Fixed3  operand to shared unit.
- mad_a  out  Fixed  operand to shared unit.
- mad_b  out  Fixed3  operand to shared unit.
- mad_ov  in  Fixed3  result from shared unit, MAD_LATENCY cycles after operands.
- res_valid  out  NUM_REQ  one-hot result strobe, one cycle, no backpressure.
- res_value  out  Fixed3  result, broadcast to all requesters, qualified by res_valid.
- busy  out  1  at least one op in flight.

## Operation
- Grant is combinational. If rst, hold or flush is 1, or no req_valid bit is set, req_ready = 0. Otherwise exactly one bit of req_ready is set: the first valid requester at or after index ptr, searching upward with wrap.
- A requester holds its operands stable while req_valid & !req_ready. req_ready may depend on req_valid.
- On a grant to g:
  - mad_c/a/b = req_c/a/b[g] in the same cycle.
  - {1, g} enters stage 0 of the tag pipe.
  - ptr <= (g+1) mod NUM_REQ.
- With no grant, mad_* = 0, {0, x} enters the tag pipe, and ptr holds.
- The tag pipe is MAD_LATENCY registers of {valid, id[$clog2(NUM_REQ)-1:0]}.
- At the last stage: res_valid = valid ? (1 << id) : 0, and res_value = mad_ov passed through combinationally. res_value is don't-care when res_valid = 0.
- In-flight counter, width $clog2(MAD_LATENCY+1):
  - +1 on grant, −1 on retire, unchanged when both occur in the same cycle.
  - Never exceeds MAD_LATENCY.
  - busy = (count != 0).
- flush: all tag valid bits and count are cleared on the next edge. No grant occurs in the flush cycle. ptr holds. Results from the discarded ops never raise res_valid.
- rst: ptr = 0, tag valid bits = 0, count = 0. Outputs during and after reset: res_valid = 0, busy = 0, req_ready = 0 (forced while rst is high), mad_* = 0.
- Arithmetic is owned by the shared unit. This block does not modify, saturate or reorder values.

## Timing
- Issue throughput: 1 op/cycle aggregate.
- Worst-case wait with all requesters continuously valid: NUM_REQ−1 cycles. No starvation.
- Latency from handshake edge (cycle T) to res_valid: T+MAD_LATENCY. Results retire in issue order.
- Requester i granted at T may present a new request at T+1. It is eligible again immediately, but ptr has moved past i.
- hold asserted in cycle T: no grant in T. In-flight ops still retire at their scheduled cycles.
- rst asserted mid-operation takes effect on the next edge. In-flight results are lost, matching flush.
- flush and a retire in the same cycle: that retire still strobes res_valid, since it is combinational from the current stage. Later stages are cleared.

## Structure
- Fixed and Fixed3 come from the shared fixed-point package, as do `FIXED_WIDTH and related macros.
- Add to that package a tag struct: {logic valid; logic [ID_W-1:0] id;}.
- One sub-module, rr_arbiter: parameterised NUM_REQ, with inputs req and ptr and a one-hot grant output. It is purely combinational.
- The scheduler instantiates rr_arbiter and implements the tag pipe, ptr and counter. The shared unit is instantiated by the parent, next to this block.

## Test plan
- Reset: hold rst 3 cycles with req_valid=4'b1111 → req_ready=0, res_valid=0, busy=0, mad_*=0. First grant after release goes to requester 0.
- Single op, MAD_LATENCY=1: requester 2 issues c=(1,2,3), a=0.5, b=(4,4,4) at T → mad_* show these operands at T. At T+1: res_valid=4'b0100, res_value=(3,4,5).
- Fairness: all four requesters valid for 8 cycles → grant order 0,1,2,3,0,1,2,3. Results strobe in the same order, each 1 cycle later.
- Wrap and skip: ptr=3, req_valid=4'b0101 → grant 0, then 2. Requester 1 (not valid) is skipped.
- hold/flush, MAD_LATENCY=3: issue 3 ops back to back, then flush while count=3 → no res_valid for those ops, busy=0 next cycle. hold=1 with requests pending → req_ready=0 until hold drops.
- Back-to-back same requester: only requester 1 valid for 5 cycles → 5 grants, 5 results, busy stays 1, count ≤ MAD_LATENCY throughout.

Source files
------------

// File: rtl/fixed3_mad_scheduler_pkg.sv
// Shared fixed-point types and the tag carried alongside each op in the MAD scheduler.
package fixed3_mad_scheduler_pkg;

  localparam int unsigned FIXED_WIDTH = 32;
  localparam int unsigned FIXED_FRAC  = 16;
  // Wide enough for up to 8 requesters.
  localparam int unsigned TAG_ID_W    = 3;

  typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } fixed3_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } mad_tag_t;

endpackage

// File: rtl/fixed3_mad_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or above ptr, wrapping.
module fixed3_mad_scheduler_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[PTR_W'(idx)]) begin
        grant_c[PTR_W'(idx)] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed3_mad_scheduler.sv
// Shares one pipelined Fixed3 multiply-add unit among NUM_REQ requesters and
// routes each result back to its issuer through a latency-matched tag pipe.
module fixed3_mad_scheduler
  import fixed3_mad_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  fixed3_t [NUM_REQ-1:0] req_c,
  input  fixed_t  [NUM_REQ-1:0] req_a,
  input  fixed3_t [NUM_REQ-1:0] req_b,
  input  logic                  hold,
  input  logic                  flush,
  output fixed3_t               mad_c,
  output fixed_t                mad_a,
  output fixed3_t               mad_b,
  input  fixed3_t               mad_ov,
  output logic [NUM_REQ-1:0]    res_valid,
  output fixed3_t               res_value,
  output logic                  busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAD_LATENCY + 1);

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic [CNT_W-1:0]   count;
  mad_tag_t           tag_pipe [MAD_LATENCY];
  mad_tag_t           tag_in;
  mad_tag_t           tag_out;

  // No new issue while reset, hold or flush is active.
  assign arb_req = (rst || hold || flush) ? '0 : req_valid;

  fixed3_mad_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (arb_req),
    .ptr     (ptr),
    .grant_c (grant)
  );

  assign req_ready = grant;
  assign gnt_any   = |grant;

  // Encode the winner and steer its operands to the shared unit.
  always_comb begin
    gnt_id = '0;
    mad_c  = '0;
    mad_a  = '0;
    mad_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_id = ID_W'(i);
        mad_c  = req_c[i];
        mad_a  = req_a[i];
        mad_b  = req_b[i];
      end
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = gnt_any;
    tag_in.id    = TAG_ID_W'(gnt_id);
  end

  assign tag_out = tag_pipe[MAD_LATENCY-1];

  always_comb begin
    res_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      res_valid[i] = !rst && tag_out.valid && (tag_out.id == TAG_ID_W'(i));
    end
  end

  assign res_value = mad_ov;
  assign busy      = !rst && (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAD_LATENCY; i++) tag_pipe[i] <= '0;
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < MAD_LATENCY; i++) tag_pipe[i] <= '0;
      count <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int unsigned i = 1; i < MAD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (gnt_any) begin
        ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end
      case ({gnt_any, tag_out.valid})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed3_mad_scheduler.sv
// Bench for fixed3_mad_scheduler: two instances (latency 1 and 3) share stimulus and
// are compared against a schedule-based reference model and directed vectors.
module tb_fixed3_mad_scheduler;
  import fixed3_mad_scheduler_pkg::*;

  localparam int unsigned NR = 4;

  logic clk;
  logic rst, hold, flush;
  logic [NR-1:0] req_valid;
  fixed3_t [NR-1:0] req_c;
  fixed_t  [NR-1:0] req_a;
  fixed3_t [NR-1:0] req_b;

  logic [NR-1:0] rdy1, rv1, rdy3, rv3;
  fixed3_t madc1, madb1, ov1, rval1, madc3, madb3, ov3, rval3;
  fixed_t mada1, mada3;
  logic busy1, busy3;

  fixed3_mad_scheduler #(.NUM_REQ(NR), .MAD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
    .req_c(req_c), .req_a(req_a), .req_b(req_b), .hold(hold), .flush(flush),
    .mad_c(madc1), .mad_a(mada1), .mad_b(madb1), .mad_ov(ov1),
    .res_valid(rv1), .res_value(rval1), .busy(busy1));

  fixed3_mad_scheduler #(.NUM_REQ(NR), .MAD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3),
    .req_c(req_c), .req_a(req_a), .req_b(req_b), .hold(hold), .flush(flush),
    .mad_c(madc3), .mad_a(mada3), .mad_b(madb3), .mad_ov(ov3),
    .res_valid(rv3), .res_value(rval3), .busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fixed3_t mad_fn(fixed3_t c, fixed_t a, fixed3_t b);
    fixed3_t r;
    longint p;
    p = longint'(a) * longint'(b.x); r.x = c.x + fixed_t'(p >>> FIXED_FRAC);
    p = longint'(a) * longint'(b.y); r.y = c.y + fixed_t'(p >>> FIXED_FRAC);
    p = longint'(a) * longint'(b.z); r.z = c.z + fixed_t'(p >>> FIXED_FRAC);
    return r;
  endfunction

  function automatic fixed_t fx(int v);
    return fixed_t'(v * 65536);
  endfunction

  // Shared multiply-add unit models, one per latency.
  fixed3_t mp1;
  fixed3_t mp3 [3];
  always @(posedge clk) begin
    mp1    <= mad_fn(madc1, mada1, madb1);
    mp3[0] <= mad_fn(madc3, mada3, madb3);
    mp3[1] <= mp3[0];
    mp3[2] <= mp3[1];
  end
  assign ov1 = mp1;
  assign ov3 = mp3[2];

  int n_pass, n_total;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: per-instance pointer and a cycle-indexed retire schedule.
  int      lat [2];
  int      ptr_m [2];
  bit      sv [2][16];
  int      sid [2][16];
  fixed3_t sval [2][16];
  int      cyc;

  function automatic int exp_grant(int p);
    if (rst || hold || flush) return -1;
    for (int k = 0; k < int'(NR); k++) begin
      if (req_valid[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_check(int d, logic [NR-1:0] rdy, logic [223:0] mad,
                             logic [NR-1:0] rv, fixed3_t rval, logic bsy);
    int g, slot;
    logic [NR-1:0] erdy, erv;
    logic [223:0] emad;
    bit ebusy;
    g    = exp_grant(ptr_m[d]);
    erdy = (g < 0) ? '0 : (NR'(1) << g);
    emad = (g < 0) ? '0 : {req_c[g], req_a[g], req_b[g]};
    chk($sformatf("lat%0d ready", lat[d]), 256'(rdy), 256'(erdy));
    chk($sformatf("lat%0d mad_ops", lat[d]), 256'(mad), 256'(emad));
    slot = cyc % 16;
    erv  = (!rst && sv[d][slot]) ? (NR'(1) << sid[d][slot]) : '0;
    chk($sformatf("lat%0d res_valid", lat[d]), 256'(rv), 256'(erv));
    if (erv != '0) chk($sformatf("lat%0d res_value", lat[d]), 256'(rval), 256'(sval[d][slot]));
    ebusy = 1'b0;
    for (int k = 0; k < lat[d]; k++) if (sv[d][(cyc + k) % 16]) ebusy = 1'b1;
    if (rst) ebusy = 1'b0;
    chk($sformatf("lat%0d busy", lat[d]), 256'(bsy), 256'(ebusy));
  endtask

  task automatic model_advance();
    for (int d = 0; d < 2; d++) begin
      int g, s;
      g = exp_grant(ptr_m[d]);
      if (rst) begin
        ptr_m[d] = 0;
        for (int k = 0; k < 16; k++) sv[d][k] = 1'b0;
      end else begin
        sv[d][cyc % 16] = 1'b0;
        if (flush) begin
          for (int k = 0; k < 16; k++) sv[d][k] = 1'b0;
        end else if (g >= 0) begin
          s = (cyc + lat[d]) % 16;
          sv[d][s]   = 1'b1;
          sid[d][s]  = g;
          sval[d][s] = mad_fn(req_c[g], req_a[g], req_b[g]);
          ptr_m[d]   = (g + 1) % NR;
        end
      end
    end
    cyc++;
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check(0, rdy1, {madc1, mada1, madb1}, rv1, rval1, busy1);
    model_check(1, rdy3, {madc3, mada3, madb3}, rv3, rval3, busy3);
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < int'(NR); i++) begin
      req_c[i].x = fixed_t'($urandom); req_c[i].y = fixed_t'($urandom); req_c[i].z = fixed_t'($urandom);
      req_a[i]   = fixed_t'($urandom);
      req_b[i].x = fixed_t'($urandom); req_b[i].y = fixed_t'($urandom); req_b[i].z = fixed_t'($urandom);
    end
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic          hold;
    logic          flush;
    logic [NR-1:0] exp_ready;
  } vec_t;

  vec_t tbl [14];
  logic [NR-1:0] order [8];
  fixed3_t c0, b0, r0;

  initial begin
    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b0, 1'b0, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0001};
    tbl[5]  = '{4'b0100, 1'b0, 1'b0, 4'b0100};
    tbl[6]  = '{4'b0101, 1'b0, 1'b0, 4'b0001};
    tbl[7]  = '{4'b0101, 1'b0, 1'b0, 4'b0100};
    tbl[8]  = '{4'b1111, 1'b1, 1'b0, 4'b0000};
    tbl[9]  = '{4'b1111, 1'b0, 1'b1, 4'b0000};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[11] = '{4'b1111, 1'b0, 1'b0, 4'b1000};
    tbl[12] = '{4'b0010, 1'b0, 1'b0, 4'b0010};
    tbl[13] = '{4'b1001, 1'b0, 1'b0, 4'b1000};

    n_pass = 0; n_total = 0; cyc = 0;
    lat[0] = 1; lat[1] = 3;
    for (int d = 0; d < 2; d++) begin
      ptr_m[d] = 0;
      for (int k = 0; k < 16; k++) sv[d][k] = 1'b0;
    end

    // Reset held for three cycles with every requester asking.
    rst = 1'b1; hold = 1'b0; flush = 1'b0; req_valid = 4'b1111;
    rand_ops();
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("rst ready", 256'({rdy1, rdy3}), 256'(0));
      chk("rst res_valid", 256'({rv1, rv3}), 256'(0));
      chk("rst busy", 256'({busy1, busy3}), 256'(0));
      chk("rst mad", 256'({madc1, mada1, madb1}), 256'(0));
      at_pos();
    end
    rst = 1'b0;

    // Directed arbitration vectors, starting from ptr = 0.
    for (int r = 0; r < 14; r++) begin
      req_valid = tbl[r].valid; hold = tbl[r].hold; flush = tbl[r].flush;
      rand_ops();
      at_neg();
      chk($sformatf("tbl%0d ready1", r), 256'(rdy1), 256'(tbl[r].exp_ready));
      chk($sformatf("tbl%0d ready3", r), 256'(rdy3), 256'(tbl[r].exp_ready));
      at_pos();
    end
    hold = 1'b0; flush = 1'b0;

    // Single op from requester 2: c=(1,2,3), a=0.5, b=(4,4,4) -> (3,4,5).
    c0 = '{fx(1), fx(2), fx(3)};
    b0 = '{fx(4), fx(4), fx(4)};
    r0 = '{fx(3), fx(4), fx(5)};
    req_valid = 4'b0100; req_c[2] = c0; req_a[2] = fixed_t'(32768); req_b[2] = b0;
    at_neg();
    chk("single ready", 256'(rdy1), 256'(4'b0100));
    chk("single mad_c", 256'(madc1), 256'(c0));
    chk("single mad_a", 256'(mada1), 256'(32'h8000));
    chk("single mad_b", 256'(madb1), 256'(b0));
    at_pos();
    req_valid = 4'b0000;
    at_neg();
    chk("single res_valid1", 256'(rv1), 256'(4'b0100));
    chk("single res_value1", 256'(rval1), 256'(r0));
    at_pos();
    at_neg(); at_pos();
    at_neg();
    chk("single res_valid3", 256'(rv3), 256'(4'b0100));
    chk("single res_value3", 256'(rval3), 256'(r0));
    at_pos();

    // Fairness from a fresh pointer.
    rst = 1'b1; at_neg(); at_pos(); rst = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      at_neg();
      order[k] = rdy1;
      chk($sformatf("fair grant%0d", k), 256'(rdy1), 256'(4'b0001 << (k % 4)));
      if (k > 0) chk($sformatf("fair result%0d", k), 256'(rv1), 256'(order[k-1]));
      at_pos();
    end
    req_valid = 4'b0000;
    at_neg();
    chk("fair result7", 256'(rv1), 256'(order[7]));
    at_pos();
    for (int k = 0; k < 3; k++) begin at_neg(); at_pos(); end
    at_neg();
    chk("drained busy3", 256'(busy3), 256'(0));
    at_pos();

    // Three back-to-back ops into the latency-3 unit, then flush at count = 3.
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin rand_ops(); at_neg(); at_pos(); end
    req_valid = 4'b1111; flush = 1'b1;
    at_neg();
    chk("flush ready3", 256'(rdy3), 256'(0));
    chk("flush busy3", 256'(busy3), 256'(1));
    chk("flush same-cycle retire", 256'(rv3), 256'(4'b0001));
    at_pos();
    flush = 1'b0; req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk($sformatf("post-flush res_valid3 %0d", k), 256'(rv3), 256'(0));
      chk($sformatf("post-flush busy3 %0d", k), 256'(busy3), 256'(0));
      at_pos();
    end

    // hold with requests pending.
    hold = 1'b1; req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk($sformatf("hold ready %0d", k), 256'({rdy1, rdy3}), 256'(0));
      at_pos();
    end
    hold = 1'b0;
    at_neg();
    chk("hold release ready3", 256'(rdy3), 256'(4'b1000));
    at_pos();

    // Same requester back to back.
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      at_neg();
      chk($sformatf("b2b ready3 %0d", k), 256'(rdy3), 256'(4'b0010));
      if (k > 0) chk($sformatf("b2b busy3 %0d", k), 256'(busy3), 256'(1));
      at_pos();
    end
    req_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin at_neg(); at_pos(); end

    // Randomized traffic with occasional hold, flush and reset.
    for (int k = 0; k < 400; k++) begin
      req_valid = NR'($urandom);
      hold  = ($urandom_range(0, 99) < 10);
      flush = ($urandom_range(0, 99) < 5);
      rst   = ($urandom_range(0, 99) < 2);
      rand_ops();
      at_neg();
      at_pos();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
